// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer.
//   DefaultWidth : default word width (and shift strobes per frame)
//   state_e      : 2-bit sequencer state encoding (Idle=0, Load=1, Shift=2, Done=3)
package shift_seq_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StShift = 2'd2,
      StDone  = 2'd3
   } state_e;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a parameterised shift register. Accepts one parallel word per
// frame on a valid/ready handshake, then drives one load strobe, WIDTH shift
// strobes and one done strobe, so the producer never times strobes itself.
//
// Optional feature: define SHIFT_SEQ_STALL_EN to add the stall input, which
// freezes the shift phase (no strobe, count and state held) while high.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : upstream word valid
//   in_ready   : sequencer idle and able to take a word
//   in_data    : upstream word
//   abort      : synchronous frame cancel (honoured in LOAD/SHIFT only)
//   stall      : shift-phase hold (SHIFT_SEQ_STALL_EN builds only)
//   sr_load    : shift register load strobe
//   sr_shift   : shift register shift strobe
//   sr_done    : shift register done strobe
//   sr_data_in : word held for the shift register
//   busy       : frame in progress
//   bit_count  : shifts issued in the current frame
//   frame_done : one-cycle end-of-frame pulse, coincident with sr_done
// All outputs come straight from flops.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
`ifdef SHIFT_SEQ_STALL_EN
   input  logic             stall,
`endif
   output logic             sr_load,
   output logic             sr_shift,
   output logic             sr_done,
   output logic [WIDTH-1:0] sr_data_in,
   output logic             busy,
   output logic [CNT_W-1:0] bit_count,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             load_q, load_d;
   logic             shift_q, shift_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             stall_w;

`ifdef SHIFT_SEQ_STALL_EN
   assign stall_w = stall;
`else
   assign stall_w = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      shift_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            // in_ready_q rather than the state: no accept on the first edge after reset
            if (in_ready_q && in_valid && !abort) begin
               state_d = StLoad;
               data_d  = in_data;
               cnt_d   = '0;
            end
         end
         StLoad: begin
            if (abort) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               // Stall is not honoured here; the first shift always follows the load
               state_d = StShift;
               shift_d = 1'b1;
               cnt_d   = CNT_W'(1);
            end
         end
         StShift: begin
            if (abort) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (stall_w) begin
               state_d = StShift;
            end else if (cnt_q >= CntMax) begin
               // The WIDTH-th strobe is already out; count holds at WIDTH through DONE
               state_d = StDone;
            end else begin
               shift_d = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      in_ready_d = (state_d == StIdle);
      load_d     = (state_d == StLoad);
      done_d     = (state_d == StDone);
      busy_d     = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         data_q     <= '0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         load_q     <= 1'b0;
         shift_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         load_q     <= load_d;
         shift_q    <= shift_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign sr_load    = load_q;
   assign sr_shift   = shift_q;
   assign sr_done    = done_q;
   assign frame_done = done_q;
   assign sr_data_in = data_q;
   assign busy       = busy_q;
   assign bit_count  = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl. Stimulus drives on the falling edge
// and pushes the predicted post-edge outputs into a queue; a monitor samples
// 2ns after each rising edge and compares against the queue head. Completed
// frames are also checked against a queue of accepted words.
module tb_shift_seq_ctrl;

   localparam int W  = 8;
   localparam int CW = 4;
`ifdef SHIFT_SEQ_STALL_EN
   localparam bit StallEn = 1'b1;
`else
   localparam bit StallEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid = 1'b0;
   logic          abort = 1'b0;
   logic          stall = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready, sr_load, sr_shift, sr_done, busy, frame_done;
   logic [W-1:0]  sr_data_in;
   logic [CW-1:0] bit_count;

   shift_seq_ctrl #(
      .WIDTH(W),
      .CNT_W(CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .abort     (abort),
`ifdef SHIFT_SEQ_STALL_EN
      .stall     (stall),
`endif
      .sr_load   (sr_load),
      .sr_shift  (sr_shift),
      .sr_done   (sr_done),
      .sr_data_in(sr_data_in),
      .busy      (busy),
      .bit_count (bit_count),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          rdy;
      logic          ld;
      logic          sh;
      logic          dn;
      logic          fd;
      logic          bsy;
      logic [CW-1:0] cnt;
      logic [W-1:0]  dat;
   } obs_t;

   obs_t         exp_q[$];
   logic [W-1:0] frame_q[$];
   int           errors = 0;
   int           checks = 0;
   int           frames_exp = 0;
   int           frames_seen = 0;
   bit           rel_pending = 1'b1;

   // Reference model: position within the frame timeline.
   // 0 idle, 1 load cycle, 2..W+1 shift cycles, W+2 done cycle.
   int           m_pos = 0;
   bit           m_ready = 1'b0;
   int           m_cnt = 0;
   logic [W-1:0] m_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus plus the model's prediction for the coming edge.
   task automatic step(input bit v, input logic [W-1:0] d, input bit ab, input bit st);
      obs_t e;
      bit   stalled;
      @(negedge clk);
      if (rel_pending) begin
         reset       = 1'b1;
         rel_pending = 1'b0;
      end
      in_valid = v;
      in_data  = d;
      abort    = ab;
      stall    = st;
      stalled  = 1'b0;
      if (m_pos == 0) begin
         if (m_ready && v && !ab) begin
            m_pos  = 1;
            m_data = d;
            m_cnt  = 0;
            frame_q.push_back(d);
         end
      end else if (m_pos == W + 2) begin
         m_pos = 0;
      end else if (ab) begin
         m_pos = 0;
         m_cnt = 0;
         if (frame_q.size() > 0) void'(frame_q.pop_back());
      end else if (StallEn && st && m_pos >= 2) begin
         stalled = 1'b1;
      end else begin
         m_pos++;
         if (m_pos <= W + 1) m_cnt = m_pos - 1;
      end
      m_ready = 1'b1;
      if (m_pos == W + 2) frames_exp++;
      e.rdy = (m_pos == 0);
      e.ld  = (m_pos == 1);
      e.sh  = (m_pos >= 2) && (m_pos <= W + 1) && !stalled;
      e.dn  = (m_pos == W + 2);
      e.fd  = (m_pos == W + 2);
      e.bsy = (m_pos != 0);
      e.cnt = CW'(m_cnt);
      e.dat = m_data;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   // Hold the word valid until the model predicts acceptance.
   task automatic send(input logic [W-1:0] w);
      bit ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         step(1'b1, w, 1'b0, 1'b0);
         ok = (m_pos == 1);
      end
      check("send accepted", 64'(ok), 64'd1);
   endtask

   task automatic run_to(input int pos);
      for (int i = 0; i < 30 && m_pos < pos; i++) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("reset drops sr_shift", 64'(sr_shift), 64'd0);
      check("reset drops busy", 64'(busy), 64'd0);
      check("reset clears bit_count", 64'(bit_count), 64'd0);
      m_pos       = 0;
      m_ready     = 1'b0;
      m_cnt       = 0;
      m_data      = '0;
      frame_q.delete();
      rel_pending = 1'b1;
   endtask

   initial begin : monitor
      obs_t a;
      obs_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{rdy: in_ready, ld: sr_load, sh: sr_shift, dn: sr_done, fd: frame_done,
                  bsy: busy, cnt: bit_count, dat: sr_data_in};
            check("outputs {rdy,ld,sh,dn,fd,busy,cnt,data}", 64'(a), 64'(e));
            if (frame_done) begin
               frames_seen++;
               if (frame_q.size() == 0) begin
                  check("unexpected frame_done", 64'd1, 64'd0);
               end else begin
                  check("frame word", 64'(sr_data_in), 64'(frame_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      reset = 1'b0;
      #7;
      check("reset in_ready", 64'(in_ready), 64'd0);
      check("reset sr_load", 64'(sr_load), 64'd0);
      check("reset sr_shift", 64'(sr_shift), 64'd0);
      check("reset sr_done", 64'(sr_done), 64'd0);
      check("reset frame_done", 64'(frame_done), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset bit_count", 64'(bit_count), 64'd0);
      check("reset sr_data_in", 64'(sr_data_in), 64'd0);

      // Single frame
      send(8'h01);
      idle(12);

      // Back-to-back words with valid held; 3C is presented while busy
      send(8'hA5);
      send(8'h3C);
      idle(12);

      // Abort after the third shift, then abort in idle blocks acceptance
      send(8'h5A);
      run_to(4);
      step(1'b0, '0, 1'b1, 1'b0);
      idle(2);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      idle(2);

      // Reset during shift, then a clean frame
      send(8'hC3);
      run_to(5);
      mid_reset();
      send(8'h96);
      idle(12);

      // Stall during shift (only meaningful when the port exists)
      send(8'hE1);
      run_to(3);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      idle(14);

      // Randomised traffic
      for (int i = 0; i < 800; i++) begin
         step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 6) == 0));
      end
      idle(15);
      @(negedge clk);
      @(negedge clk);
      check("frame count", 64'(frames_seen), 64'(frames_exp));
      check("expectation queue drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
